mngr_chan_buf: RTL and testbench

//  Elastic buffer between the test manager and the core's manager ports (mngr2proc/proc2mngr).
//  Two independent val/rdy FIFOs: RX carries manager->core words, TX carries core->manager words.

---
 rtl/mngr_chan_buf_if.sv | 39 +++
 rtl/mngr_chan_buf.sv | 99 +++++++++
 tb/tb_mngr_chan_buf.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mngr_chan_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : mngr_chan_buf_if
// Description : Handshake bundle between the test manager, mngr_chan_buf and the core.
// Revision    : 1.0
// ============================================================================
interface mngr_chan_buf_if #(
    parameter int W = 32
);
    logic         mngr2proc_val;
    logic         mngr2proc_rdy;
    logic [W-1:0] mngr2proc_msg;
    logic         proc_rx_val;
    logic         proc_rx_rdy;
    logic [W-1:0] proc_rx_msg;
    logic         proc_tx_val;
    logic         proc_tx_rdy;
    logic [W-1:0] proc_tx_msg;
    logic         proc2mngr_val;
    logic         proc2mngr_rdy;
    logic [W-1:0] proc2mngr_msg;

    // Buffer side
    modport slave (
        input  mngr2proc_val, mngr2proc_msg, proc_rx_rdy,
        input  proc_tx_val, proc_tx_msg, proc2mngr_rdy,
        output mngr2proc_rdy, proc_rx_val, proc_rx_msg,
        output proc_tx_rdy, proc2mngr_val, proc2mngr_msg
    );

    // Manager + core side
    modport master (
        output mngr2proc_val, mngr2proc_msg, proc_rx_rdy,
        output proc_tx_val, proc_tx_msg, proc2mngr_rdy,
        input  mngr2proc_rdy, proc_rx_val, proc_rx_msg,
        input  proc_tx_rdy, proc2mngr_val, proc2mngr_msg
    );
endinterface
`default_nettype wire

// File: rtl/mngr_chan_buf.sv
`default_nettype none
// ============================================================================
// Module      : mngr_chan_buf
// Description : Two independent val/rdy FIFOs (RX: manager->core, TX: core->manager).
// Revision    : 1.0
// ============================================================================
module mngr_chan_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    mngr_chan_buf_if.slave                  bus,
    output logic [$clog2(DEPTH+1)-1:0]      rx_count,
    output logic [$clog2(DEPTH+1)-1:0]      tx_count,
    output logic [31:0]                     rx_xfers,
    output logic [31:0]                     tx_xfers
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Channel 0 = RX, channel 1 = TX
    logic [1:0]          w_in_val;
    logic [1:0][W-1:0]   w_in_msg;
    logic [1:0]          w_in_rdy;
    logic [1:0]          w_out_val;
    logic [1:0]          w_out_rdy;
    logic [1:0][W-1:0]   w_out_msg;
    logic [1:0][CW-1:0]  w_count;
    logic [1:0][31:0]    w_xfers;

    assign w_in_val  = {bus.proc_tx_val, bus.mngr2proc_val};
    assign w_in_msg  = {bus.proc_tx_msg, bus.mngr2proc_msg};
    assign w_out_rdy = {bus.proc2mngr_rdy, bus.proc_rx_rdy};

    assign bus.mngr2proc_rdy = w_in_rdy[0];
    assign bus.proc_tx_rdy   = w_in_rdy[1];
    assign bus.proc_rx_val   = w_out_val[0];
    assign bus.proc2mngr_val = w_out_val[1];
    assign bus.proc_rx_msg   = w_out_msg[0];
    assign bus.proc2mngr_msg = w_out_msg[1];
    assign rx_count          = w_count[0];
    assign tx_count          = w_count[1];
    assign rx_xfers          = w_xfers[0];
    assign tx_xfers          = w_xfers[1];

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [W-1:0]  mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q, wr_ptr_d;
        logic [AW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;
        logic          rdy_q, rdy_d;
        logic [31:0]   xfers_q, xfers_d;
        logic          w_enq;
        logic          w_deq;

        assign w_enq = w_in_val[c] && rdy_q;
        assign w_deq = w_out_rdy[c] && (count_q != '0);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (w_enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_deq) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(w_enq) - CW'(w_deq);
            // rdy is a flop of the next count, so a full FIFO cannot pass through
            rdy_d   = (count_d != CW'(DEPTH));
            // RX counts manager-side writes, TX counts manager-side reads
            xfers_d = xfers_q + 32'((c == 0) ? w_enq : w_deq);
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                rdy_q    <= 1'b0;
                xfers_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                rdy_q    <= rdy_d;
                xfers_q  <= xfers_d;
            end
        end

        always_ff @(posedge clk) begin
            if (w_enq) mem_q[wr_ptr_q] <= w_in_msg[c];
        end

        assign w_in_rdy[c]  = rdy_q;
        assign w_out_val[c] = (count_q != '0);
        assign w_out_msg[c] = mem_q[rd_ptr_q];
        assign w_count[c]   = count_q;
        assign w_xfers[c]   = xfers_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_mngr_chan_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mngr_chan_buf
// Description : Directed + random stimulus against a queue model of both FIFOs.
// Revision    : 1.0
// ============================================================================
module tb_mngr_chan_buf;
    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mngr_chan_buf_if #(.W(W)) bus ();
    logic [CW-1:0] rx_count, tx_count;
    logic [31:0]   rx_xfers, tx_xfers;

    mngr_chan_buf #(.DEPTH(DEPTH), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .rx_count (rx_count),
        .tx_count (tx_count),
        .rx_xfers (rx_xfers),
        .tx_xfers (tx_xfers)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q_rx[$];
    logic [W-1:0] q_tx[$];
    logic [W-1:0] got_rx[$];
    logic [W-1:0] got_tx[$];
    int unsigned  m_rx_xfers = 0;
    int unsigned  m_tx_xfers = 0;
    bit           m_known    = 1'b0;
    bit           m_rdy_up   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        if (!m_known) return;
        check_eq("rx_rdy",   bus.mngr2proc_rdy, 64'(m_rdy_up && q_rx.size() != DEPTH));
        check_eq("rx_val",   bus.proc_rx_val,   64'(q_rx.size() != 0));
        if (q_rx.size() != 0) check_eq("rx_msg", bus.proc_rx_msg, q_rx[0]);
        check_eq("rx_count", rx_count,          q_rx.size());
        check_eq("tx_rdy",   bus.proc_tx_rdy,   64'(m_rdy_up && q_tx.size() != DEPTH));
        check_eq("tx_val",   bus.proc2mngr_val, 64'(q_tx.size() != 0));
        if (q_tx.size() != 0) check_eq("tx_msg", bus.proc2mngr_msg, q_tx[0]);
        check_eq("tx_count", tx_count,          q_tx.size());
        check_eq("rx_xfers", rx_xfers,          m_rx_xfers);
        check_eq("tx_xfers", tx_xfers,          m_tx_xfers);
    endtask

    // One clock: check outputs, drive inputs, advance the model, return at negedge
    task automatic step(input bit r, input bit mv, input logic [W-1:0] mm, input bit crr,
                        input bit cv, input logic [W-1:0] cm, input bit mr);
        bit rx_enq, rx_deq, tx_enq, tx_deq;
        check_model();
        rst               = r;
        bus.mngr2proc_val = mv;
        bus.mngr2proc_msg = mm;
        bus.proc_rx_rdy   = crr;
        bus.proc_tx_val   = cv;
        bus.proc_tx_msg   = cm;
        bus.proc2mngr_rdy = mr;
        rx_enq = mv  && m_rdy_up && (q_rx.size() != DEPTH);
        rx_deq = crr && (q_rx.size() != 0);
        tx_enq = cv  && m_rdy_up && (q_tx.size() != DEPTH);
        tx_deq = mr  && (q_tx.size() != 0);
        if (r && bus.proc_rx_val === 1'b1 && crr)  got_rx.push_back(bus.proc_rx_msg);
        if (r && bus.proc2mngr_val === 1'b1 && mr) got_tx.push_back(bus.proc2mngr_msg);
        @(posedge clk);
        if (!r) begin
            q_rx.delete();
            q_tx.delete();
            m_rx_xfers = 0;
            m_tx_xfers = 0;
            m_rdy_up   = 1'b0;
            m_known    = 1'b1;
        end else if (m_known) begin
            if (rx_deq) void'(q_rx.pop_front());
            if (rx_enq) begin q_rx.push_back(mm); m_rx_xfers++; end
            if (tx_deq) begin void'(q_tx.pop_front()); m_tx_xfers++; end
            if (tx_enq) q_tx.push_back(cm);
            m_rdy_up = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] v;
        int idx;
        int budget;
        bus.mngr2proc_val = 1'b0; bus.mngr2proc_msg = '0; bus.proc_rx_rdy = 1'b0;
        bus.proc_tx_val   = 1'b0; bus.proc_tx_msg   = '0; bus.proc2mngr_rdy = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("rst_rx_rdy", bus.mngr2proc_rdy, 0);
        check_eq("rst_tx_rdy", bus.proc_tx_rdy, 0);
        idle();

        // Single word round trip through the core
        step(1'b1, 1'b1, 32'd33, 1'b0, 1'b0, '0, 1'b0);
        check_eq("t1_val", bus.proc_rx_val, 1);
        check_eq("t1_msg", bus.proc_rx_msg, 33);
        check_eq("t1_xfers", rx_xfers, 1);
        v = q_rx[0] + 32'd42;
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, v, 1'b0);
        check_eq("t2_val", bus.proc2mngr_val, 1);
        check_eq("t2_msg", bus.proc2mngr_msg, 75);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        check_eq("t2_xfers", tx_xfers, 1);

        // Fill RX to full with a blocked core, then drain
        got_rx.delete();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'(i), 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'd5, 1'b0, 1'b0, '0, 1'b0);
        check_eq("t3_full_rdy", bus.mngr2proc_rdy, 0);
        check_eq("t3_count", rx_count, 4);
        step(1'b1, 1'b1, 32'd5, 1'b1, 1'b0, '0, 1'b0);
        check_eq("t3_no_passthru", rx_count, 3);
        step(1'b1, 1'b1, 32'd5, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) idle_drain: step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check_eq("t3_n", got_rx.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_rx.size()) check_eq("t3_order", got_rx[i], 32'(i + 1));
        end

        // Steady enq+deq at occupancy 2
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h101, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, $urandom, 1'b1, 1'b0, '0, 1'b0);
        check_eq("t4_count", rx_count, 2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        // TX streaming with toggling manager ready
        got_tx.delete();
        idx = 0;
        budget = 0;
        while (got_tx.size() < 16 && budget < 200) begin
            bit acc;
            acc = (idx < 16) && m_rdy_up && (q_tx.size() != DEPTH);
            step(1'b1, 1'b0, '0, 1'b0, idx < 16, 32'hA0 + 32'(idx), budget[0] == 1'b0);
            if (acc) idx++;
            budget++;
        end
        check_eq("t5_n", got_tx.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_tx.size()) check_eq("t5_order", got_tx[i], 32'hA0 + 32'(i));
        end

        // Random traffic on both channels
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'($urandom), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom), $urandom, 1'($urandom_range(0, 2) == 0));
        end

        // Reset mid-operation
        for (int i = 0; i < 6; i++) idle_dr2: step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, $urandom, 1'b0, i < 2, $urandom, 1'b0);
        check_eq("t6_pre_rx", rx_count, 3);
        check_eq("t6_pre_tx", tx_count, 2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("t6_rx_count", rx_count, 0);
        check_eq("t6_tx_count", tx_count, 0);
        check_eq("t6_rx_val", bus.proc_rx_val, 0);
        check_eq("t6_tx_val", bus.proc2mngr_val, 0);
        check_eq("t6_rx_xfers", rx_xfers, 0);
        check_eq("t6_tx_xfers", tx_xfers, 0);
        idle();
        check_eq("t6_rdy_back", bus.mngr2proc_rdy, 1);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
